status_reporter: RTL and testbench
==================================

STATUS_REPORTER -- requirements
Module: status_reporter

Interface
REQ-001 SHALL have parameter BOOT_REPORT, default 1, meaning 1 sends one status message after reset release and 0 sends none.
REQ-002 SHALL have parameter AUTO_REPORT, default 1, meaning 1 sends a message on any status change and 0 sends only on req_dump.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mode  input  2  current operating mode: 0 watch, 1 stopwatch, 2 sr04, 3 dht11.
REQ-006 SHALL have port c_runset  input  1  current watch run/set state.
REQ-007 SHALL have port c_display  input  1  current display-select state.
REQ-008 SHALL have port req_dump  input  1  single-cycle request to send the current status unconditionally.
REQ-009 SHALL have port tx_ready  input  1  UART transmit path can accept a byte this cycle.
REQ-010 SHALL have port tx_valid  output  1  tx_data holds a byte to transfer.
REQ-011 SHALL have port tx_data  output  8  ASCII byte to transmit.
REQ-012 SHALL have port busy  output  1  high while a message is in progress.

Function
REQ-013 Status word SHALL be S = {mode, c_runset, c_display} (4 bits).
REQ-014 A message SHALL be exactly 8 bytes: 0x4D 'M', 0x30+mode, 0x52 'R', 0x30+runset, 0x44 'D', 0x30+display, 0x0D, 0x0A.
REQ-015 Message content SHALL come from a snapshot of S latched when the message starts; input changes during a message do not alter it.
REQ-016 States SHALL be IDLE and SEND; byte index idx is 3 bits, 0..7.
REQ-017 In IDLE, a trigger sampled at edge N SHALL latch the snapshot, set idx=0 and enter SEND, with tx_valid=1 and tx_data=byte 0 from edge N onward.
REQ-018 The trigger SHALL be any of: boot_pending; dump_pending or req_dump; AUTO_REPORT=1 and S differs from last_sent.
REQ-019 A byte SHALL transfer only on an edge where tx_valid and tx_ready are both 1; tx_data and tx_valid stay stable until that transfer.
REQ-020 On transfer with idx<7, idx SHALL increment and tx_data take the next byte in the same edge, with no idle cycle between bytes.
REQ-021 On transfer with idx=7, last_sent SHALL take the snapshot, the block returns to IDLE, and tx_valid and busy go low for at least one cycle before any next message.
REQ-022 busy SHALL equal (state==SEND).
REQ-023 req_dump in SEND SHALL set dump_pending; multiple requests SHALL collapse into one extra message, and the flag clears when that message starts.
REQ-024 Status changes during SEND SHALL not queue; after return to IDLE, REQ-018 compares the then-current S against last_sent, so intermediate values are dropped and only the latest is reported.
REQ-025 req_dump in the same edge as a status change in IDLE SHALL produce exactly one message.
REQ-026 boot_pending SHALL clear when the boot message starts.

Reset
REQ-027 While rst=0, the block SHALL be in IDLE with tx_valid=0, tx_data=0x00, busy=0, idx=0, snapshot=0, last_sent=0, dump_pending=0, and boot_pending=BOOT_REPORT.
REQ-028 Asserting rst mid-message SHALL abort the message immediately (asynchronous); a partial message is never resumed.

Verification
REQ-029 Boot: BOOT_REPORT=1, S=0, tx_ready=1 -> bytes 4D 30 52 30 44 30 0D 0A on 8 consecutive edges, then busy=0 and no further traffic.
REQ-030 Change: idle, mode 0->2 at edge N -> tx_valid=1 from edge N, message "M2R0D0\r\n"; with BOOT_REPORT=0 and no change, no traffic.
REQ-031 Backpressure: tx_ready=0 for 5 cycles while byte 3 is presented -> tx_data held at 0x30, message completes with no byte skipped or duplicated.
REQ-032 Coalescing: mode set to 1 then to 3 during a message -> exactly one follow-up message, "M3...", and no "M1" message.
REQ-033 Dump: req_dump with S unchanged -> identical message resent; three req_dump pulses during SEND -> exactly one extra message.
REQ-034 Reset abort: rst=0 during byte 4 -> tx_valid=0 asynchronously; after release with BOOT_REPORT=1 -> full message restarts from 0x4D.

Source files
------------

// File: rtl/status_reporter.sv
// Serialises the 4-bit status word {mode, runset, display} as the ASCII line "M<m>R<r>D<d>\r\n"
// over a valid/ready byte stream, on boot, on status change, or on explicit dump request.
module status_reporter #(
  parameter int unsigned BOOT_REPORT = 1,
  parameter int unsigned AUTO_REPORT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       c_runset,
  input  logic       c_display,
  input  logic       req_dump,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy
);

  typedef enum logic {StIdle, StSend} state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] snap_q, snap_d;
  logic [3:0] last_q, last_d;
  logic       dump_q, dump_d;
  logic       boot_q, boot_d;

  logic [3:0] status;
  logic       trigger;
  logic       xfer;

  assign status  = {mode, c_runset, c_display};
  assign trigger = boot_q || dump_q || req_dump || ((AUTO_REPORT != 0) && (status != last_q));
  assign xfer    = (state_q == StSend) && tx_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    last_d  = last_q;
    dump_d  = dump_q;
    boot_d  = boot_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StSend;
          idx_d   = 3'd0;
          snap_d  = status;
          dump_d  = 1'b0;
          boot_d  = 1'b0;
        end
      end
      StSend: begin
        // Requests arriving mid-message collapse into a single follow-up message.
        if (req_dump) dump_d = 1'b1;
        if (xfer) begin
          if (idx_q == 3'd7) begin
            state_d = StIdle;
            last_d  = snap_q;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      snap_q  <= 4'd0;
      last_q  <= 4'd0;
      dump_q  <= 1'b0;
      boot_q  <= (BOOT_REPORT != 0);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      last_q  <= last_d;
      dump_q  <= dump_d;
      boot_q  <= boot_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset silences them at once.
  always_comb begin
    tx_data = 8'h00;
    if (state_q == StSend) begin
      unique case (idx_q)
        3'd0:    tx_data = 8'h4D;
        3'd1:    tx_data = 8'h30 + {6'd0, snap_q[3:2]};
        3'd2:    tx_data = 8'h52;
        3'd3:    tx_data = 8'h30 + {7'd0, snap_q[1]};
        3'd4:    tx_data = 8'h44;
        3'd5:    tx_data = 8'h30 + {7'd0, snap_q[0]};
        3'd6:    tx_data = 8'h0D;
        default: tx_data = 8'h0A;
      endcase
    end
  end

  assign tx_valid = (state_q == StSend);
  assign busy     = (state_q == StSend);

endmodule

// File: tb/tb_status_reporter.sv
// Bench for status_reporter: two instances (defaults, and no-boot/no-auto) against a
// message-buffer reference model, with directed scenarios followed by random traffic.
module tb_status_reporter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       c_runset = 1'b0;
  logic       c_display = 1'b0;
  logic       req_dump = 1'b0;
  logic       tx_ready = 1'b1;

  logic       tx_valid0, busy0, tx_valid1, busy1;
  logic [7:0] tx_data0, tx_data1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  status_reporter #(.BOOT_REPORT(1), .AUTO_REPORT(1)) dut (
    .clk(clk), .rst(rst), .mode(mode), .c_runset(c_runset), .c_display(c_display),
    .req_dump(req_dump), .tx_ready(tx_ready),
    .tx_valid(tx_valid0), .tx_data(tx_data0), .busy(busy0)
  );

  status_reporter #(.BOOT_REPORT(0), .AUTO_REPORT(0)) dut_nb (
    .clk(clk), .rst(rst), .mode(mode), .c_runset(c_runset), .c_display(c_display),
    .req_dump(req_dump), .tx_ready(tx_ready),
    .tx_valid(tx_valid1), .tx_data(tx_data1), .busy(busy1)
  );

  // Reference model: per instance, the message text being sent and how many bytes remain.
  logic [7:0] msg [2][8];
  int         rem [2];
  logic [3:0] last [2];
  logic [3:0] snap [2];
  logic       dump_p [2];
  logic       boot_p [2];
  logic       p_boot [2] = '{1'b1, 1'b0};
  logic       p_auto [2] = '{1'b1, 1'b0};
  int         m1_seen, m3_seen, msgs0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; last[k] = 4'd0; snap[k] = 4'd0; dump_p[k] = 1'b0; boot_p[k] = p_boot[k];
    end
  endtask

  task automatic model_edge();
    logic [3:0] s;
    s = {mode, c_runset, c_display};
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        rem[k] = 0; last[k] = 4'd0; snap[k] = 4'd0; dump_p[k] = 1'b0; boot_p[k] = p_boot[k];
      end else if (rem[k] == 0) begin
        if (boot_p[k] || dump_p[k] || req_dump || (p_auto[k] && s != last[k])) begin
          snap[k] = s;
          msg[k][0] = "M"; msg[k][1] = 8'h30 + 8'(s[3:2]);
          msg[k][2] = "R"; msg[k][3] = 8'h30 + 8'(s[1]);
          msg[k][4] = "D"; msg[k][5] = 8'h30 + 8'(s[0]);
          msg[k][6] = 8'h0D; msg[k][7] = 8'h0A;
          rem[k] = 8; boot_p[k] = 1'b0; dump_p[k] = 1'b0;
          if (k == 0) begin
            msgs0++;
            if (s[3:2] == 2'd1) m1_seen++;
            if (s[3:2] == 2'd3) m3_seen++;
          end
        end
      end else begin
        if (req_dump) dump_p[k] = 1'b1;
        if (tx_ready) begin
          rem[k]--;
          if (rem[k] == 0) last[k] = snap[k];
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("valid0", {7'd0, tx_valid0}, {7'd0, rem[0] > 0});
    chk("busy0", {7'd0, busy0}, {7'd0, rem[0] > 0});
    chk("data0", tx_data0, (rem[0] > 0) ? msg[0][8 - rem[0]] : 8'h00);
    chk("valid1", {7'd0, tx_valid1}, {7'd0, rem[1] > 0});
    chk("busy1", {7'd0, busy1}, {7'd0, rem[1] > 0});
    chk("data1", tx_data1, (rem[1] > 0) ? msg[1][8 - rem[1]] : 8'h00);
  endtask

  // One clock: model at the edge, DUT sampled 1 time unit later, one-shot req_dump dropped.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    req_dump = 1'b0;
  endtask

  task automatic wait_rem(input int target, input string tag);
    int n;
    n = 0;
    while (rem[0] != target && n < 40) begin step(); n++; end
    checks++;
    assert (rem[0] == target) else begin
      errors++;
      $error("FAIL %s timeout observed_rem=%0d expected_rem=%0d", tag, rem[0], target);
    end
  endtask

  initial begin
    model_reset();
    m1_seen = 0; m3_seen = 0; msgs0 = 0;
    #2;
    compare_all();
    chk("reset_data", tx_data0, 8'h00);
    step();
    #2 rst = 1'b1;

    // Boot message on 8 consecutive edges; dut_nb stays silent.
    step();
    chk("boot_first", tx_data0, 8'h4D);
    for (int i = 0; i < 7; i++) step();
    chk("boot_last", tx_data0, 8'h0A);
    step();
    chk("boot_done_busy", {7'd0, busy0}, 8'd0);
    for (int i = 0; i < 3; i++) step();

    // Status change to mode 2; backpressure while byte 3 is presented.
    mode = 2'd2;
    step();
    chk("chg_start", tx_data0, 8'h4D);
    step();
    chk("chg_mode", tx_data0, 8'h32);
    wait_rem(5, "bp_reach");
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", tx_data0, 8'h30);
    end
    tx_ready = 1'b1;
    wait_rem(0, "bp_finish");

    // Coalescing: 1 then 3 during a message yields only an M3 follow-up.
    req_dump = 1'b1;
    step();
    m1_seen = 0; m3_seen = 0;
    step(); mode = 2'd1;
    step(); step(); mode = 2'd3;
    wait_rem(0, "coal_first");
    step();
    wait_rem(0, "coal_second");
    for (int i = 0; i < 3; i++) step();
    chk("coal_m1", 8'(m1_seen), 8'd0);
    chk("coal_m3", 8'(m3_seen), 8'd1);

    // Dump with unchanged status, then three dumps during SEND -> one extra.
    msgs0 = 0;
    req_dump = 1'b1;
    step();
    step(); req_dump = 1'b1; step(); step(); req_dump = 1'b1; step(); req_dump = 1'b1; step();
    wait_rem(0, "dump_first");
    step();
    wait_rem(0, "dump_extra");
    for (int i = 0; i < 4; i++) step();
    chk("dump_count", 8'(msgs0), 8'd2);

    // Asynchronous reset while byte 4 is presented.
    req_dump = 1'b1;
    step();
    wait_rem(4, "abort_reach");
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("abort_valid", {7'd0, tx_valid0}, 8'd0);
    chk("abort_busy", {7'd0, busy0}, 8'd0);
    step(); step();
    #2 rst = 1'b1;
    step();
    chk("restart_first", tx_data0, 8'h4D);
    wait_rem(0, "restart_done");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        mode = 2'($urandom_range(0, 3));
        c_runset = 1'($urandom_range(0, 1));
        c_display = 1'($urandom_range(0, 1));
      end
      req_dump = ($urandom_range(0, 29) == 0);
      step();
    end

    tx_ready = 1'b1;
    for (int i = 0; i < 30; i++) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
